// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-to-UART drain block.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Bits needed to hold 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_uart_drain_baud_tick.sv
// Bit-period counter: ticks on its last count and restarts from 0 on clear.
module baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from the capture FIFO one at a time and serialises each onto a UART TX line.
module fifo_uart_drain
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done,
  output logic [CNT_WIDTH-1:0]  o_bytes_sent,
  output logic [2:0]            o_state
);

  localparam int BIT_W = clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  // Handshake: o_fifo_rd is a one-cycle pop issued only from IDLE while the FIFO
  // reports non-empty; the popped word is sampled from i_fifo_data one cycle later.

  state_t                r_state;
  state_t                w_next;
  logic                  w_tick;
  logic                  w_adv;
  logic                  w_clear;
  logic                  w_last_stop;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]      r_bit_idx;
  logic                  r_stop_idx;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_fifo_rd;
  logic                  r_tx_done;
  logic [CNT_WIDTH-1:0]  r_bytes_sent;

  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_en && !i_fifo_empty) w_next = S_RD;
      S_RD:    w_next = S_LATCH;
      S_LATCH: w_next = S_START;
      S_START: if (w_tick) w_next = S_DATA;
      S_DATA: begin
        if (w_tick && (r_bit_idx == LAST_BIT))
          w_next = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
      end
      S_PAR:   if (w_tick) w_next = S_STOP;
      S_STOP:  if (w_tick && w_last_stop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The bit counter is held at zero outside bit periods so every period is full length.
  always_comb begin
    o_busy  = (r_state != S_IDLE);
    w_adv   = w_tick && ((r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PAR)   || (r_state == S_STOP));
    w_clear = w_adv || (r_state == S_IDLE) || (r_state == S_RD) || (r_state == S_LATCH);
  end

  assign w_shift_nxt = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_par_bit    <= 1'b0;
      r_tx         <= 1'b1;
      r_fifo_rd    <= 1'b0;
      r_tx_done    <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      r_fifo_rd <= (r_state == S_IDLE) && (w_next == S_RD);
      r_tx_done <= 1'b0;
      case (r_state)
        S_LATCH: begin
          r_shift   <= i_fifo_data;
          r_par_bit <= (PARITY == PAR_ODD) ? ~(^i_fifo_data) : (^i_fifo_data);
          r_tx      <= 1'b0;
        end
        S_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_tx       <= (PARITY != PAR_NONE) ? r_par_bit : 1'b1;
              r_stop_idx <= 1'b0;
            end else begin
              r_shift   <= w_shift_nxt;
              r_tx      <= w_shift_nxt[0];
              r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_tx <= 1'b1;
            if (w_last_stop) begin
              r_tx_done    <= 1'b1;
              r_bytes_sent <= r_bytes_sent + CNT_WIDTH'(1);
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign o_fifo_rd    = r_fifo_rd;
  assign o_tx_done    = r_tx_done;
  assign o_bytes_sent = r_bytes_sent;
  assign o_state      = r_state;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench: three drain instances (no parity / even+2 stop / odd) each fed by a 1-cycle-latency FIFO model.
module tb_fifo_uart_drain;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] empty_v;
  logic [2:0] rd_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [7:0] fdata [3];
  logic [3:0]  bytes0;
  logic [15:0] bytes1;
  logic [15:0] bytes2;
  logic [2:0]  st0, st1, st2;

  logic [7:0] mem [3][64];
  int wp [3];
  int rp [3];
  int pops [3];
  int bad_rd;
  int cyc;
  int last_rd_cyc;
  int checks;
  int errors;

  fifo_uart_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .CNT_WIDTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .i_en(en), .i_fifo_empty(empty_v[0]), .i_fifo_data(fdata[0]),
    .o_fifo_rd(rd_v[0]), .o_tx(tx_v[0]), .o_busy(busy_v[0]), .o_tx_done(done_v[0]),
    .o_bytes_sent(bytes0), .o_state(st0));

  fifo_uart_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .i_en(en), .i_fifo_empty(empty_v[1]), .i_fifo_data(fdata[1]),
    .o_fifo_rd(rd_v[1]), .o_tx(tx_v[1]), .o_busy(busy_v[1]), .o_tx_done(done_v[1]),
    .o_bytes_sent(bytes1), .o_state(st1));

  fifo_uart_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .CNT_WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .i_en(en), .i_fifo_empty(empty_v[2]), .i_fifo_data(fdata[2]),
    .o_fifo_rd(rd_v[2]), .o_tx(tx_v[2]), .o_busy(busy_v[2]), .o_tx_done(done_v[2]),
    .o_bytes_sent(bytes2), .o_state(st2));

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: pop on a registered strobe, data valid the following cycle
  assign empty_v[0] = (wp[0] == rp[0]);
  assign empty_v[1] = (wp[1] == rp[1]);
  assign empty_v[2] = (wp[2] == rp[2]);

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_v[i] && (rp[i] != wp[i])) begin
        fdata[i] <= mem[i][rp[i]];
        rp[i]    <= rp[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_v[i]) begin
        pops[i] = pops[i] + 1;
        if (empty_v[i]) bad_rd = bad_rd + 1;
      end
    end
    if (rd_v[0]) last_rd_cyc = cyc;
  end

  task automatic push(input int s, input logic [7:0] b);
    mem[s][wp[s]] = b;
    wp[s] = wp[s] + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps to negedges until the start bit of instance s appears (bounded).
  task automatic wait_start(input int s, input string tag, output int waited, output logic ok);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_v[2'(s)] !== 1'b0 && waited < 200);
    ok = (tx_v[2'(s)] === 1'b0);
    chk({tag, "_start_seen"}, {31'd0, ok}, 32'd1);
  endtask

  // Checks every cycle of one frame (4 clocks per bit) and the tx_done pulse after it.
  task automatic check_frame(input int s, input logic [7:0] b, input int has_par,
                             input logic par_bit, input int nstop, input string tag,
                             output int waited, output int start_cyc, output int done_cyc);
    logic exp_bits [12];
    int   n;
    logic ok;
    n = 0;
    exp_bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < 8; i++) begin
      exp_bits[n] = b[i]; n = n + 1;
    end
    if (has_par != 0) begin
      exp_bits[n] = par_bit; n = n + 1;
    end
    for (int i = 0; i < nstop; i++) begin
      exp_bits[n] = 1'b1; n = n + 1;
    end
    wait_start(s, tag, waited, ok);
    start_cyc = cyc;
    done_cyc  = cyc;
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        for (int c = 0; c < 4; c++) begin
          if (!(k == 0 && c == 0)) @(negedge clk);
          chk($sformatf("%s_bit%0d", tag, k), {31'd0, tx_v[2'(s)]}, {31'd0, exp_bits[k]});
        end
      end
      @(negedge clk);
      done_cyc = cyc;
      chk({tag, "_tx_done"}, {31'd0, done_v[2'(s)]}, 32'd1);
    end
  endtask

  initial begin
    int w, sc, dc, p0;
    logic ok;
    checks = 0; errors = 0; bad_rd = 0; last_rd_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0; rp[i] = 0; pops[i] = 0; fdata[i] = 8'h00;
    end
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", {31'd0, tx_v[0]}, 32'd1);
    chk("rst_fifo_rd", {31'd0, rd_v[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rst_tx_done", {31'd0, done_v[0]}, 32'd0);
    chk("rst_bytes", {28'd0, bytes0}, 32'd0);
    chk("rst_state", {29'd0, st0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte 0xA5, no parity -> 0,1,0,1,0,0,1,0,1,1
    push(0, 8'hA5);
    en = 1'b1;
    check_frame(0, 8'hA5, 0, 1'b0, 1, "t1", w, sc, dc);
    chk("t1_latency", 32'(sc - last_rd_cyc), 32'd2);
    chk("t1_frame_len", 32'(dc - sc), 32'd40);
    chk("t1_bytes", {28'd0, bytes0}, 32'd1);
    chk("t1_pops", 32'(pops[0]), 32'd1);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, done_v[0]}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy_v[0]}, 32'd0);

    // 2: burst of three with exactly 3 idle-high cycles between frames
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h3C);
    check_frame(0, 8'h00, 0, 1'b0, 1, "t2_b0", w, sc, dc);
    check_frame(0, 8'hFF, 0, 1'b0, 1, "t2_b1", w, sc, dc);
    chk("t2_gap1", 32'(w), 32'd3);
    check_frame(0, 8'h3C, 0, 1'b0, 1, "t2_b2", w, sc, dc);
    chk("t2_gap2", 32'(w), 32'd3);
    chk("t2_bytes", {28'd0, bytes0}, 32'd3);
    chk("t2_pops", 32'(pops[0]), 32'd4);

    // 3: parity. Even with 0x07 -> 1, even with 0xA5 -> 0 (2 stop bits); odd with 0x07 -> 0, 0x00 -> 1
    push(1, 8'h07); push(1, 8'hA5);
    check_frame(1, 8'h07, 1, 1'b1, 2, "t3_even07", w, sc, dc);
    chk("t3_even_len", 32'(dc - sc), 32'd48);
    check_frame(1, 8'hA5, 1, 1'b0, 2, "t3_evenA5", w, sc, dc);
    chk("t3_even_bytes", {16'd0, bytes1}, 32'd2);
    push(2, 8'h07); push(2, 8'h00);
    check_frame(2, 8'h07, 1, 1'b0, 1, "t3_odd07", w, sc, dc);
    check_frame(2, 8'h00, 1, 1'b1, 1, "t3_odd00", w, sc, dc);
    chk("t3_odd_len", 32'(dc - sc), 32'd44);
    chk("t3_odd_bytes", {16'd0, bytes2}, 32'd2);

    // 4: en dropped during DATA of byte 1 with two queued
    p0 = pops[0];
    push(0, 8'h96); push(0, 8'h4B);
    fork
      check_frame(0, 8'h96, 0, 1'b0, 1, "t4_b1", w, sc, dc);
      begin
        repeat (12) @(negedge clk);
        en = 1'b0;
      end
    join
    chk("t4_one_pop", 32'(pops[0] - p0), 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_no_more_pop", 32'(pops[0] - p0), 32'd1);
    chk("t4_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("t4_tx_idle", {31'd0, tx_v[0]}, 32'd1);
    en = 1'b1;
    check_frame(0, 8'h4B, 0, 1'b0, 1, "t4_b2", w, sc, dc);
    chk("t4_bytes", {28'd0, bytes0}, 32'd5);

    // 5: reset during data bit 3 aborts the frame; the popped byte is lost
    push(0, 8'h5A); push(0, 8'hC3);
    wait_start(0, "t5", w, ok);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx", {31'd0, tx_v[0]}, 32'd1);
    chk("t5_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("t5_fifo_rd", {31'd0, rd_v[0]}, 32'd0);
    chk("t5_bytes", {28'd0, bytes0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_pop_after_rst", {31'd0, rd_v[0]}, 32'd1);
    check_frame(0, 8'hC3, 0, 1'b0, 1, "t5_next", w, sc, dc);
    chk("t5_next_wait", 32'(w), 32'd2);
    chk("t5_bytes_after", {28'd0, bytes0}, 32'd1);

    // 6: 4-bit counter wraps after 16 frames; then an empty FIFO never pops
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 17; i++) push(0, 8'(i * 37 + 5));
    for (int i = 0; i < 17; i++) begin
      check_frame(0, 8'(i * 37 + 5), 0, 1'b0, 1, $sformatf("t6_f%0d", i), w, sc, dc);
    end
    chk("t6_bytes_wrap", {28'd0, bytes0}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t6_empty_idle", {30'd0, rd_v[0], tx_v[0]}, 32'd1);
    end
    chk("rd_while_empty", 32'(bad_rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_drain.md
Name: fifo_uart_drain

Overview:
Read-side consumer for the camera byte FIFO. It watches the FIFO empty flag, pops one byte at a time with a single-cycle read strobe, and serialises each byte onto a UART TX line. Frames are 8N1 by default, with optional parity and 1 or 2 stop bits. It sits between the capture FIFO and the board's debug/host UART pin.

Parameters:
DATA_WIDTH, 8, FIFO word width and UART data bits per frame
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range is 2 or more
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
CNT_WIDTH, 16, width of the sent-byte counter

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  drain enable; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd
fifo_rd  output  1  FIFO pop strobe, registered, one-cycle pulse
tx  output  1  UART serial out, idle high
busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse after the last stop bit completes
bytes_sent  output  CNT_WIDTH  count of completed frames, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset values: tx=1, fifo_rd=0, busy=0, tx_done=0, bytes_sent=0, state=IDLE, baud_cnt=0, bit_idx=0, shift_reg=0.
- Reset asserted mid-frame aborts the frame. tx is 1 after that edge. A byte already popped is discarded.
- States: IDLE, RD, LATCH, START, DATA, PAR, STOP.
- IDLE: at the edge where en=1 and fifo_empty=0, go to RD and set fifo_rd=1.
- RD: at the next edge, fifo_rd=0 and go to LATCH. The FIFO drives fifo_data during this cycle.
- LATCH: at the next edge, shift_reg <= fifo_data, tx <= 0, baud_cnt <= 0, go to START.
- Pop-to-start-bit latency is 2 cycles from the fifo_rd pulse.
- Every bit period lasts exactly CLKS_PER_BIT cycles.
- baud_cnt counts 0..CLKS_PER_BIT-1. The bit advances when baud_cnt == CLKS_PER_BIT-1.
- START: after one period, tx <= shift_reg[0] and go to DATA with bit_idx=0.
- DATA: bits are sent LSB first. At the end of each period, shift right and increment bit_idx.
- DATA exit: after bit DATA_WIDTH-1, go to PAR if PARITY != 0, else to STOP.
- Parity bit: even parity = XOR of the data bits; odd parity = its inverse. It is computed from the byte captured in LATCH.
- STOP: tx=1 for STOP_BITS periods.
- STOP exit: at the final edge, bytes_sent increments, tx_done=1 for exactly one cycle, and the state returns to IDLE.
- Back-to-back frames: IDLE→RD→LATCH adds 3 idle-high cycles between frames. Idle time is never shorter than this.
- fifo_empty and en are ignored outside IDLE. Deasserting en mid-frame lets the current frame finish, and no further pop occurs.
- fifo_rd is never asserted while fifo_empty=1 in the same cycle it is issued. Exactly one pop occurs per frame.
- bytes_sent wraps from all-ones to 0 without any flag.
- busy = (state != IDLE), decoded combinationally from the state register.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum (7 states)
  - parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - the helper function clog2 used for the baud_cnt width
- Sub-module baud_tick:
  - a counter with clear input and parameter CLKS_PER_BIT
  - produces a one-cycle tick at CLKS_PER_BIT-1
  - the FSM clears it on LATCH and on every bit advance.

Test Plan:
Run with CLKS_PER_BIT=4 and a behavioural FIFO model with 1-cycle read latency.
1. Single byte: FIFO holds 0xA5, en=1, PARITY=0 → one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done one cycle later; bytes_sent=1; 40 cycles from start bit to tx_done.
2. Burst of 0x00, 0xFF, 0x3C → three pops, three frames in order, exactly 3 high cycles between each stop end and the next start bit; bytes_sent=3.
3. Parity: PARITY=2 with 0x07 → parity bit 1; PARITY=1 with 0x07 → parity bit 0; STOP_BITS=2 → stop high for 8 cycles.
4. en dropped during the DATA state of byte 1 with 2 bytes queued → byte 1 completes, no further fifo_rd, busy=0; re-raise en → byte 2 sent.
5. rst pulsed during bit 3 of a frame → tx=1, busy=0, fifo_rd=0 after the edge, bytes_sent=0; with the FIFO non-empty, a new pop occurs 1 cycle after rst is released.
6. CNT_WIDTH=4, 17 bytes sent → bytes_sent reads 1; empty FIFO with en=1 held for 100 cycles → fifo_rd never asserted and tx stays 1.
